// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encodings, opcodes and ALU-op codes shared by the multi-cycle control FSM.
package mc_ctrl_pkg;
    typedef enum logic [3:0] {
        INIT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    function automatic logic is_wait(input state_t s);
        return s inside {FETCH, MEMRD, MEMWR};
    endfunction
endpackage

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: Moore control FSM for the multi-cycle datapath with
// memory-ready handshake and timeout trap.
module multi_cycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSource,
    output logic [1:0] aluInstruct,
    output logic       illegalOp,
    output logic       memTimeout
);
    localparam logic [7:0] LAST_CNT = 8'(MEM_TIMEOUT - 1);

    state_t     r_state, w_next;
    logic [7:0] r_wait_cnt;
    logic       r_cause;
    logic       w_wait, w_expire;

    assign w_wait   = is_wait(r_state);
    assign w_expire = w_wait && !memReady && r_wait_cnt == LAST_CNT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= INIT;
            r_wait_cnt <= '0;
            r_cause    <= 1'b0;
        end else begin
            r_state    <= w_next;
            // Only wait states ever loop on themselves, so any transition clears the count.
            r_wait_cnt <= (w_next == r_state && w_wait) ? r_wait_cnt + 8'd1 : '0;
            r_cause    <= w_expire ? 1'b1 : (r_state == DECODE) ? 1'b0 : r_cause;
        end
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            INIT:    w_next = FETCH;
            FETCH:   w_next = memReady ? DECODE : w_expire ? TRAP : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = EXECUTE;
                    OP_BEQ:       w_next = BRANCH;
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JUMP;
                    default:      w_next = TRAP;
                endcase
            end
            MEMADR:  w_next = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   w_next = memReady ? MEMWB : w_expire ? TRAP : MEMRD;
            MEMWR:   w_next = memReady ? FETCH : w_expire ? TRAP : MEMWR;
            EXECUTE: w_next = ALUWB;
            ADDIEX:  w_next = ADDIWB;
            default: w_next = FETCH;
        endcase
    end

    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        pcSource    = 2'b00;
        aluInstruct = ALUOP_ADD;
        illegalOp   = 1'b0;
        memTimeout  = 1'b0;
        case (r_state)
            FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
            end
            DECODE:  aluSrcB = 2'b11;
            MEMADR, ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            EXECUTE: begin
                aluSrcA     = 1'b1;
                aluInstruct = ALUOP_FUNCT;
            end
            ALUWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            BRANCH: begin
                aluSrcA     = 1'b1;
                aluInstruct = ALUOP_SUB;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
            end
            ADDIWB:  regWrite = 1'b1;
            JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
            TRAP: begin
                illegalOp  = !r_cause;
                memTimeout = r_cause;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Main control FSM for the multi-cycle datapath revision; the producer side of the 2-bit ALU-op interface.
- Decodes the instruction opcode and sequences fetch/decode/execute/memory/writeback over several cycles.
- Drives aluInstruct[1:0] into the existing ALU-control decoder and all datapath mux/enable strobes.
- Waits on a memory-ready handshake, with a timeout trap.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles to wait for memReady in a memory state before trapping; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- opcode  input  6  instruction[31:26] from the instruction register
- memReady  input  1  memory completes the current access this cycle
- pcWrite  output  1  unconditional PC load
- pcWriteCond  output  1  PC load if ALU zero
- iorD  output  1  memory address source: 0=PC, 1=ALUOut
- memRead  output  1  memory read request
- memWrite  output  1  memory write request
- irWrite  output  1  instruction register load
- memToReg  output  1  register write data source: 0=ALUOut, 1=MDR
- regDst  output  1  destination register: 0=rt, 1=rd
- regWrite  output  1  register file write enable
- aluSrcA  output  1  ALU A input: 0=PC, 1=A register
- aluSrcB  output  2  ALU B input: 00=B, 01=4, 10=signext imm, 11=signext imm<<2
- pcSource  output  2  next PC: 00=ALU, 01=ALUOut, 10=jump target
- aluInstruct  output  2  00=add, 01=subtract, 10=use funct field
- illegalOp  output  1  one-cycle pulse; unknown opcode
- memTimeout  output  1  one-cycle pulse; memReady not received in time

Behaviour:
- Async reset: state=INIT and waitCnt=0 immediately. All outputs are 0 while in INIT.
- INIT lasts exactly one clock after reset deasserts, then the FSM moves to FETCH.
- Outputs are decoded from the state register (Moore). The only exceptions are pcWrite and irWrite in FETCH, which are additionally gated by memReady.
- Any output not listed for a state is 0.
- States, outputs and transitions:
  - FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluInstruct=00, pcSource=00; irWrite=pcWrite=memReady. Go to DECODE when memReady=1.
  - DECODE: aluSrcA=0, aluSrcB=11, aluInstruct=00. Dispatch on opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 -> EXECUTE
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - anything else -> TRAP
  - MEMADR: aluSrcA=1, aluSrcB=10, aluInstruct=00. Go to MEMRD if lw, MEMWR if sw.
  - MEMRD: memRead=1, iorD=1. Go to MEMWB on memReady.
  - MEMWB: regWrite=1, memToReg=1, regDst=0. Go to FETCH.
  - MEMWR: memWrite=1, iorD=1. Go to FETCH on memReady.
  - EXECUTE: aluSrcA=1, aluSrcB=00, aluInstruct=10. Go to ALUWB.
  - ALUWB: regWrite=1, regDst=1, memToReg=0. Go to FETCH.
  - BRANCH: aluSrcA=1, aluSrcB=00, aluInstruct=01, pcWriteCond=1, pcSource=01. Go to FETCH.
  - ADDIEX: aluSrcA=1, aluSrcB=10, aluInstruct=00. Go to ADDIWB.
  - ADDIWB: regWrite=1, regDst=0, memToReg=0. Go to FETCH.
  - JUMP: pcWrite=1, pcSource=10. Go to FETCH.
  - TRAP: illegalOp or memTimeout as latched from the cause. Go to FETCH.
- Wait counter (8-bit waitCnt):
  - Cleared on entry to FETCH, MEMRD and MEMWR.
  - Increments each cycle spent in one of those states with memReady=0.
  - If memReady=0 and waitCnt==MEM_TIMEOUT-1: go to TRAP with cause=timeout. No irWrite/pcWrite is issued.
  - memReady=1 on the same cycle the count expires wins; the access completes normally.
- Trap cause: a 1-bit register set in DECODE (illegal) or in a wait state (timeout). Exactly one of illegalOp/memTimeout pulses in TRAP.
- opcode is sampled in DECODE and in MEMADR only. The IR is stable because irWrite is 0 outside FETCH.
- aluInstruct=11 is never driven.
- Reset asserted mid-instruction: outputs drop to 0 asynchronously. No partial write completes after reset assertion.

Decomposition:
- Package mc_ctrl_pkg holds:
  - 4-bit state encodings (INIT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - aluInstruct constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
- No sub-module. Next-state logic, wait counter and output decode live in one module.

Test Plan:
- Reset release, opcode=000000, memReady=1 always: INIT, FETCH, DECODE, EXECUTE (aluInstruct=10), ALUWB (regWrite=1, regDst=1), FETCH. R-type takes 4 cycles after INIT.
- opcode=100011, memReady low for 3 cycles in MEMRD: FETCH, DECODE, MEMADR (aluSrcB=10), MEMRD held 4 cycles with memRead=iorD=1, MEMWB (memToReg=1).
- opcode=000100: BRANCH shows aluInstruct=01, pcWriteCond=1, pcSource=01 for exactly 1 cycle. Repeat with opcode=000010: JUMP shows pcWrite=1, pcSource=10.
- opcode=111111: DECODE, then TRAP with illegalOp=1 for 1 cycle and memTimeout=0, then FETCH.
- MEM_TIMEOUT=4, memReady held 0 in FETCH: after 4 FETCH cycles, TRAP with memTimeout=1, and irWrite/pcWrite never asserted. Repeat with memReady=1 on the 4th cycle: goes to DECODE, no trap.
- Reset asserted during MEMWR with memWrite=1: memWrite falls in the same cycle (async). After release: one INIT cycle, then FETCH.
